// File: rtl/operand_fetch_ctrl_pkg.sv
// Shared definitions for the memory-to-memory transfer path: FSM state
// encodings and default word/address widths.
package operand_fetch_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD1     = 3'd1,
        ST_RD2     = 3'd2,
        ST_CAP     = 3'd3,
        ST_PRESENT = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/operand_fetch_ctrl_pair_addr_gen.sv
// Address walker for operand fetch: loads the base address and pair count,
// then advances two words per accepted pair and flags the final pair.
module operand_fetch_ctrl_pair_addr_gen #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] num,
    output logic [ADDR_W-1:0] addr,
    output logic              last_pair
);

    logic [ADDR_W-1:0] remaining;

    // Address wraps naturally at 2**ADDR_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
        end else if (load) begin
            addr      <= base;
            remaining <= num;
        end else if (step) begin
            addr      <= addr + ADDR_W'(2);
            remaining <= remaining - ADDR_W'(1);
        end
    end

    assign last_pair = (remaining == ADDR_W'(1));

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch controller: reads DOut1/DOut2 pairs from a 1-cycle-latency RAM
// and presents them over valid/ready. Optional PAIR_COUNT_EN adds pair_cnt.
//
// state   | meaning
// IDLE    | waiting for start; base/num latched on start
// RD1     | read DOut1 word at A
// RD2     | read DOut2 word at A+1; capture DOut1
// CAP     | capture DOut2
// PRESENT | op_valid high until op_ready; then A+=2
// DONE    | one-cycle done pulse
module operand_fetch_ctrl
    import operand_fetch_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_pairs,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] DOut1,
    output logic [DATA_W-1:0] DOut2,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              busy,
    output logic              done
`ifdef PAIR_COUNT_EN
    ,
    output logic [ADDR_W-1:0] pair_cnt
`endif
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cur_addr;
    logic              last_pair;
    logic              load;
    logic              step;
    logic              cap1;
    logic              cap2;

    operand_fetch_ctrl_pair_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_pair_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .base     (base_addr),
        .num      (num_pairs),
        .addr     (cur_addr),
        .last_pair(last_pair)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Visible outputs depend on state only; op_ready just steers next state.
    always_comb begin
        state_next = state;
        mem_addr   = '0;
        mem_rd_en  = 1'b0;
        op_valid   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        cap1       = 1'b0;
        cap2       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = (num_pairs == '0) ? ST_DONE : ST_RD1;
                end
            end
            ST_RD1: begin
                busy       = 1'b1;
                mem_rd_en  = 1'b1;
                mem_addr   = cur_addr;
                state_next = ST_RD2;
            end
            ST_RD2: begin
                busy       = 1'b1;
                mem_rd_en  = 1'b1;
                mem_addr   = cur_addr + ADDR_W'(1);
                cap1       = 1'b1;
                state_next = ST_CAP;
            end
            ST_CAP: begin
                busy       = 1'b1;
                cap2       = 1'b1;
                state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                busy     = 1'b1;
                op_valid = 1'b1;
                if (op_ready) begin
                    step       = 1'b1;
                    state_next = last_pair ? ST_DONE : ST_RD1;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            DOut1 <= '0;
            DOut2 <= '0;
        end else begin
            if (cap1) DOut1 <= mem_rdata;
            if (cap2) DOut2 <= mem_rdata;
        end
    end

`ifdef PAIR_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pair_cnt <= '0;
        end else if (load) begin
            pair_cnt <= '0;
        end else if (step) begin
            pair_cnt <= pair_cnt + ADDR_W'(1);
        end
    end
`endif

endmodule
